// File: rtl/scaler_cfg_seq.sv
// scaler_cfg_seq
//   Configuration sequencer for the H and V frac_interp scaler instances.
//   On start it latches the output window size and the interpolator operands,
//   requests the H interpolator and waits for it, then does the same for V.
//   It then derives centring offsets from the anticipated output sizes and
//   publishes a valid configuration.
//
// Parameters
//   bitwidth  width of all pixel/line counts
//   timeout   max cycles to wait for an interpolator ready (>= 2)
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   start                          pulse: latch sizes, (re)run the sequence
//   src_w, src_h, dst_w, dst_h     input active size / output window size
//   h_num, h_den, h_limit          operands to H interpolator (held stable)
//   h_newfraction                  1-cycle request to H interpolator
//   h_ready, h_limit_out           H interpolator done / anticipated output width
//   v_*                            same set for the V interpolator
//   h_centre_offset                leading blank pixels
//   v_centre_offset                leading blank lines
//   cfg_valid                      offsets and interpolators consistent
//   busy                           sequence in progress
//   err_clamp                      an illegal ratio was forced to 1:1 (sticky)
//   err_timeout                    an interpolator failed to respond (sticky)

module scaler_cfg_seq #(
    parameter int unsigned bitwidth = 10,
    parameter int unsigned timeout  = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [bitwidth-1:0] src_w,
    input  logic [bitwidth-1:0] src_h,
    input  logic [bitwidth-1:0] dst_w,
    input  logic [bitwidth-1:0] dst_h,
    output logic [bitwidth-1:0] h_num,
    output logic [bitwidth-1:0] h_den,
    output logic [bitwidth-1:0] h_limit,
    output logic                h_newfraction,
    input  logic                h_ready,
    input  logic [bitwidth-1:0] h_limit_out,
    output logic [bitwidth-1:0] v_num,
    output logic [bitwidth-1:0] v_den,
    output logic [bitwidth-1:0] v_limit,
    output logic                v_newfraction,
    input  logic                v_ready,
    input  logic [bitwidth-1:0] v_limit_out,
    output logic [bitwidth-1:0] h_centre_offset,
    output logic [bitwidth-1:0] v_centre_offset,
    output logic                cfg_valid,
    output logic                busy,
    output logic                err_clamp,
    output logic                err_timeout
);

    localparam int unsigned CW = (timeout > 2) ? $clog2(timeout) : 1;
    localparam logic [CW-1:0] TMAX = CW'(timeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        H_REQ,
        H_WAIT,
        V_REQ,
        V_WAIT,
        CENTRE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [bitwidth-1:0] dst_w_q, dst_h_q;

    logic                h_clamp, v_clamp;
    logic                wait_expired;
    logic [bitwidth-1:0] h_off_d, v_off_d;

    // A zero source or a downscale request cannot be expressed by the
    // interpolator; both fall back to 1:1 over the source extent.
    always_comb begin
        h_clamp = (src_w == '0) || (dst_w < src_w);
        v_clamp = (src_h == '0) || (dst_h < src_h);
    end

    always_comb begin
        h_off_d = '0;
        v_off_d = '0;
        if (dst_w_q >= h_limit_out) h_off_d = (dst_w_q - h_limit_out) >> 1;
        if (dst_h_q >= v_limit_out) v_off_d = (dst_h_q - v_limit_out) >> 1;
    end

    // Ready takes priority over an expiring counter in the same cycle.
    always_comb begin
        wait_expired = 1'b0;
        if (state_q == H_WAIT && !h_ready && cnt_q == TMAX) wait_expired = 1'b1;
        if (state_q == V_WAIT && !v_ready && cnt_q == TMAX) wait_expired = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = H_REQ;
        end else begin
            unique case (state_q)
                IDLE:   state_d = IDLE;
                H_REQ:  state_d = H_WAIT;
                H_WAIT: begin
                    if (h_ready)           state_d = V_REQ;
                    else if (wait_expired) state_d = IDLE;
                end
                V_REQ:  state_d = V_WAIT;
                V_WAIT: begin
                    if (v_ready)           state_d = CENTRE;
                    else if (wait_expired) state_d = IDLE;
                end
                CENTRE: state_d = DONE;
                DONE:   state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        h_newfraction = (state_q == H_REQ);
        v_newfraction = (state_q == V_REQ);
        cfg_valid     = (state_q == DONE);
        busy          = (state_q != IDLE) && (state_q != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dst_w_q         <= '0;
            dst_h_q         <= '0;
            h_num           <= '0;
            h_den           <= '0;
            h_limit         <= '0;
            v_num           <= '0;
            v_den           <= '0;
            v_limit         <= '0;
            h_centre_offset <= '0;
            v_centre_offset <= '0;
            err_clamp       <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == H_WAIT || state_q == V_WAIT) cnt_q <= cnt_q + 1'b1;
            else                                         cnt_q <= '0;

            if (start) begin
                dst_w_q     <= dst_w;
                dst_h_q     <= dst_h;
                h_num       <= h_clamp ? bitwidth'(1) : dst_w;
                h_den       <= h_clamp ? bitwidth'(1) : src_w;
                h_limit     <= src_w;
                v_num       <= v_clamp ? bitwidth'(1) : dst_h;
                v_den       <= v_clamp ? bitwidth'(1) : src_h;
                v_limit     <= src_h;
                err_clamp   <= h_clamp | v_clamp;
                err_timeout <= 1'b0;
            end else begin
                if (wait_expired) err_timeout <= 1'b1;
                if (state_q == CENTRE) begin
                    h_centre_offset <= h_off_d;
                    v_centre_offset <= v_off_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_scaler_cfg_seq.sv
module tb_scaler_cfg_seq;

    localparam int unsigned BW = 10;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [BW-1:0] src_w, src_h, dst_w, dst_h;
    logic [BW-1:0] h_num, h_den, h_limit, v_num, v_den, v_limit;
    logic          h_newfraction, v_newfraction, h_ready, v_ready;
    logic [BW-1:0] h_limit_out, v_limit_out;
    logic [BW-1:0] h_centre_offset, v_centre_offset;
    logic          cfg_valid, busy, err_clamp, err_timeout;

    int vectors = 0;
    int miscompares = 0;

    scaler_cfg_seq #(.bitwidth(BW), .timeout(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
        .h_num(h_num), .h_den(h_den), .h_limit(h_limit),
        .h_newfraction(h_newfraction), .h_ready(h_ready), .h_limit_out(h_limit_out),
        .v_num(v_num), .v_den(v_den), .v_limit(v_limit),
        .v_newfraction(v_newfraction), .v_ready(v_ready), .v_limit_out(v_limit_out),
        .h_centre_offset(h_centre_offset), .v_centre_offset(v_centre_offset),
        .cfg_valid(cfg_valid), .busy(busy),
        .err_clamp(err_clamp), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives start for exactly one rising edge; returns at the following
    // falling edge, i.e. with the sequencer in H_REQ.
    task automatic pulse_start(input logic [BW-1:0] sw, sh, dw, dh);
        src_w = sw; src_h = sh; dst_w = dw; dst_h = dh;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cfg(input int max);
        int n = 0;
        while (!cfg_valid && n < max) begin
            tick();
            n++;
        end
        chk("cfg_valid_reached", cfg_valid, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ops"}, {h_num, h_den, h_limit}, 0);
        chk({tag, "_vops"}, {v_num, v_den, v_limit}, 0);
        chk({tag, "_offs"}, {h_centre_offset, v_centre_offset}, 0);
        chk({tag, "_flags"}, {h_newfraction, v_newfraction, cfg_valid, busy, err_clamp, err_timeout}, 0);
    endtask

    initial begin
        int lat;
        logic seen;

        reset = 1'b1; start = 1'b0;
        src_w = '0; src_h = '0; dst_w = '0; dst_h = '0;
        h_ready = 1'b0; v_ready = 1'b0; h_limit_out = '0; v_limit_out = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // 320x200 -> 800x600, slow interpolators, v_ready stray during H_WAIT
        v_ready = 1'b1;
        pulse_start(320, 200, 800, 600);
        chk("a_hnf", h_newfraction, 1);
        chk("a_hops", {h_num, h_den, h_limit}, {2'b0, 10'd800, 10'd320, 10'd320});
        chk("a_vops", {v_num, v_den, v_limit}, {2'b0, 10'd600, 10'd200, 10'd200});
        chk("a_busy", {busy, cfg_valid}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | v_newfraction | h_newfraction;
        end
        chk("a_no_stray_nf", seen, 0);
        v_ready = 1'b0; h_ready = 1'b1; h_limit_out = 640;
        tick();
        h_ready = 1'b0;
        chk("a_vnf", v_newfraction, 1);
        repeat (10) tick();
        v_ready = 1'b1; v_limit_out = 600;
        tick();
        v_ready = 1'b0;
        chk("a_centre", {busy, cfg_valid}, 2'b10);
        tick();
        chk("a_done", {busy, cfg_valid, err_clamp, err_timeout}, 4'b0100);
        chk("a_hoff", h_centre_offset, 80);
        chk("a_voff", v_centre_offset, 0);

        // Immediate ready: latency and odd-difference floor
        h_ready = 1'b1; v_ready = 1'b1; h_limit_out = 640; v_limit_out = 480;
        src_w = 320; src_h = 240; dst_w = 801; dst_h = 480;
        start = 1'b1;
        lat = 0;
        while (lat < 20) begin
            tick();
            start = 1'b0;
            lat++;
            if (cfg_valid) break;
        end
        chk("lat_min", lat, 6);
        chk("odd_hoff", h_centre_offset, 80);
        chk("odd_voff", v_centre_offset, 0);

        // Downscale request on H is clamped to 1:1
        h_limit_out = 700; v_limit_out = 400;
        pulse_start(700, 200, 640, 400);
        chk("clamp_hops", {h_num, h_den, h_limit}, {2'b0, 10'd1, 10'd1, 10'd700});
        chk("clamp_vops", {v_num, v_den}, {10'd400, 10'd200});
        chk("clamp_err", err_clamp, 1);
        wait_cfg(20);
        chk("clamp_sticky", err_clamp, 1);
        chk("clamp_offs", {h_centre_offset, v_centre_offset}, 0);

        // H interpolator never answers
        h_ready = 1'b0; v_ready = 1'b0;
        pulse_start(320, 200, 640, 400);
        chk("to_errs_cleared", {err_clamp, err_timeout}, 0);
        tick();
        seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            seen = seen | v_newfraction;
            if (i == 15) chk("to_before", {err_timeout, busy}, 2'b01);
            if (i == 16) chk("to_hit", {err_timeout, busy, cfg_valid}, 3'b100);
        end
        repeat (3) tick();
        chk("to_no_vnf", seen, 0);
        chk("to_sticky_idle", {err_timeout, busy}, 2'b10);

        // Restart during V_WAIT with new sizes
        h_ready = 1'b1; v_ready = 1'b0; h_limit_out = 600; v_limit_out = 400;
        pulse_start(320, 200, 800, 600);
        chk("rs_err_cleared", err_timeout, 0);
        tick();
        tick();
        chk("rs_vnf", v_newfraction, 1);
        tick();
        tick();
        chk("rs_in_vwait", {busy, v_newfraction, h_newfraction}, 3'b100);
        pulse_start(400, 300, 640, 480);
        chk("rs_hnf_again", {h_newfraction, v_newfraction}, 2'b10);
        chk("rs_ops", {h_num, h_den, v_num, v_den}, {10'd640, 10'd400, 10'd480, 10'd300});
        v_ready = 1'b1;
        wait_cfg(20);
        chk("rs_hoff", h_centre_offset, 20);
        chk("rs_voff", v_centre_offset, 40);

        // Reset mid-H_WAIT, with start coincident with reset
        h_ready = 1'b0; v_ready = 1'b0;
        pulse_start(320, 200, 800, 600);
        tick();
        tick();
        reset = 1'b1; start = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0; start = 1'b0;
        tick();
        chk("midreset_idle", {busy, h_newfraction, v_newfraction}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
